operand_fetch_stage: RTL

// Parametrised successor of the data-processing operand read stage. Accepts decoded
// DP instruction fields, issues register-file read addresses (Rn, Rm, Rs), then forms

---
 rtl/operand_fetch_stage.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch for data-processing instructions: stage A issues register-file reads,
// stage B forms operand_1 and the barrel-shifted operand_2 with shifter carry-out.
module operand_fetch_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              dp_dt,
    input  logic              r_i,
    input  logic [REG_AW-1:0] reg_n,
    input  logic [11:0]       operand,
    input  logic              carry_in,
    output logic [REG_AW-1:0] rf_addr_1,
    output logic [REG_AW-1:0] rf_addr_2,
    output logic [REG_AW-1:0] rf_addr_s,
    output logic              rf_en_1,
    output logic              rf_en_2,
    output logic              rf_en_s,
    input  logic [DATA_W-1:0] rf_data_1,
    input  logic [DATA_W-1:0] rf_data_2,
    input  logic [DATA_W-1:0] rf_data_s,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] operand_1,
    output logic [DATA_W-1:0] operand_2,
    output logic              shift_c
);

    logic              a_valid;
    logic              a_dp;
    logic              a_ri;
    logic              a_cin;
    logic [11:0]       a_op;
    logic              advance;
    logic [DATA_W-1:0] d_1;
    logic [DATA_W-1:0] d_2;
    logic [DATA_W-1:0] d_s;
    logic [DATA_W:0]   res;
    logic [DATA_W-1:0] op1_n;
    logic [DATA_W-1:0] op2_n;
    logic              c_n;
    logic [1:0]        typ;

    assign advance  = !out_valid || out_ready;
    assign in_ready = !a_valid || advance;

    // Generic shifter returning {carry, value}; amt is the full shift count,
    // with the count-equals-width and beyond-width cases handled explicitly.
    function automatic logic [DATA_W:0] shift_rot(input logic [1:0] t_typ, input int amt,
                                                  input logic [DATA_W-1:0] x, input logic cin);
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] t;
        logic              c;
        int                r;
        v = x;
        c = cin;
        t = '0;
        r = amt % DATA_W;
        if (amt != 0) begin
            case (t_typ)
                2'b00: begin
                    if (amt < DATA_W) begin
                        v = x << amt;
                        t = x >> (DATA_W - amt);
                        c = t[0];
                    end else begin
                        v = '0;
                        c = (amt == DATA_W) ? x[0] : 1'b0;
                    end
                end
                2'b01: begin
                    if (amt < DATA_W) begin
                        v = x >> amt;
                        t = x >> (amt - 1);
                        c = t[0];
                    end else begin
                        v = '0;
                        c = (amt == DATA_W) ? x[DATA_W-1] : 1'b0;
                    end
                end
                2'b10: begin
                    if (amt < DATA_W) begin
                        v = $signed(x) >>> amt;
                        t = x >> (amt - 1);
                        c = t[0];
                    end else begin
                        v = {DATA_W{x[DATA_W-1]}};
                        c = x[DATA_W-1];
                    end
                end
                default: begin
                    if (r == 0) begin
                        c = x[DATA_W-1];
                    end else begin
                        v = (x >> r) | (x << (DATA_W - r));
                        c = v[DATA_W-1];
                    end
                end
            endcase
        end
        return {c, v};
    endfunction

    // A writeback landing in the same cycle as the stage-B capture beats the stale read.
    always_comb begin
        d_1 = rf_data_1;
        d_2 = rf_data_2;
        d_s = rf_data_s;
        if (FWD_EN && wb_en && rf_en_1 && (wb_addr == rf_addr_1)) d_1 = wb_data;
        if (FWD_EN && wb_en && rf_en_2 && (wb_addr == rf_addr_2)) d_2 = wb_data;
        if (FWD_EN && wb_en && rf_en_s && (wb_addr == rf_addr_s)) d_s = wb_data;
    end

    always_comb begin
        typ   = a_op[6:5];
        res   = {a_cin, {DATA_W{1'b0}}};
        op1_n = '0;
        op2_n = '0;
        c_n   = a_cin;
        if (a_dp) begin
            op1_n = d_1;
            if (!a_ri)
                res = shift_rot(2'b11, 2 * int'(a_op[11:8]), DATA_W'(a_op[7:0]), a_cin);
            else if (a_op[4])
                res = shift_rot(typ, int'(d_s[7:0]), d_2, a_cin);
            else if ((a_op[11:7] == 5'd0) && (typ == 2'b11))
                res = {d_2[0], a_cin, d_2[DATA_W-1:1]};
            else if ((a_op[11:7] == 5'd0) && (typ != 2'b00))
                res = shift_rot(typ, DATA_W, d_2, a_cin);
            else
                res = shift_rot(typ, int'(a_op[11:7]), d_2, a_cin);
            op2_n = res[DATA_W-1:0];
            c_n   = res[DATA_W];
        end
    end

    // Stage A holds the decoded fields and drives the register-file read ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid   <= 1'b0;
            a_dp      <= 1'b0;
            a_ri      <= 1'b0;
            a_cin     <= 1'b0;
            a_op      <= '0;
            rf_addr_1 <= '0;
            rf_addr_2 <= '0;
            rf_addr_s <= '0;
            rf_en_1   <= 1'b0;
            rf_en_2   <= 1'b0;
            rf_en_s   <= 1'b0;
        end else if (in_ready) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_dp      <= dp_dt;
                a_ri      <= r_i;
                a_cin     <= carry_in;
                a_op      <= operand;
                rf_addr_1 <= reg_n;
                rf_addr_2 <= operand[3:0];
                rf_addr_s <= operand[11:8];
                rf_en_1   <= dp_dt;
                rf_en_2   <= dp_dt & r_i;
                rf_en_s   <= dp_dt & r_i & operand[4];
            end else begin
                rf_en_1 <= 1'b0;
                rf_en_2 <= 1'b0;
                rf_en_s <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            operand_1 <= '0;
            operand_2 <= '0;
            shift_c   <= 1'b0;
        end else if (advance) begin
            out_valid <= a_valid;
            if (a_valid) begin
                operand_1 <= op1_n;
                operand_2 <= op2_n;
                shift_c   <= c_n;
            end
        end
    end

endmodule
